// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder.
// Packs opcode and register/immediate fields into 16-bit instruction words
// and writes them into instruction memory. The core is held idle while a
// program is loading. It is released only when the program is complete and
// every opcode in it was legal.
module instr_stream_encoder #(
   parameter int ADDR_W = 8,
   parameter int ERR_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [3:0]        in_fa,
   input  logic [3:0]        in_fb,
   input  logic [3:0]        in_fc,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic [ADDR_W:0]   prog_len,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              bad_op,
   output logic              full,
   output logic              done,
   output logic              core_run
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // prog_len is one bit wider than an address, so it can read DEPTH once
   // memory is full. Its low bits serve as the write pointer.
   localparam logic [ADDR_W:0]  LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]  LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

   logic [1:0]        state_q,    state_d;
   logic [ADDR_W:0]   prog_len_q, prog_len_d;
   logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
   logic              bad_op_q,   bad_op_d;
   logic              full_q,     full_d;
   logic              mem_we_q,   mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;

   logic              op_legal;
   logic              beat_acc;
   logic [ADDR_W-1:0] wptr;

   assign wptr     = prog_len_q[ADDR_W-1:0];
   assign in_ready = (state_q == ST_LOAD);
   assign beat_acc = in_valid & in_ready;

   // Decode the opcode set the pipeline's decoder understands.
   always_comb begin
      op_legal = 1'b0;
      case (in_opcode)
         4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111: op_legal = 1'b1;
         default:                                     op_legal = 1'b0;
      endcase
   end

   // Next-state and next-output logic for the load session.
   always_comb begin
      // NOTE: every signal gets a default first so no path can leave one unassigned and infer a latch.
      state_d     = state_q;
      prog_len_d  = prog_len_q;
      err_cnt_d   = err_cnt_q;
      bad_op_d    = bad_op_q;
      full_d      = full_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d    = ST_LOAD;
               prog_len_d = '0;
               err_cnt_d  = '0;
               bad_op_d   = 1'b0;
               full_d     = 1'b0;
            end
         end
         ST_LOAD: begin
            if (beat_acc) begin
               if (op_legal) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = wptr;
                  mem_wdata_d = {in_opcode, in_fa, in_fb, in_fc};
                  prog_len_d  = prog_len_q + LEN_ONE;
                  if (prog_len_q == LAST_IDX) begin
                     full_d  = 1'b1;
                     state_d = ST_DONE;
                  end else if (in_last) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  if (err_cnt_q != ERR_MAX) begin
                     err_cnt_d = err_cnt_q + ERR_ONE;
                  end
                  bad_op_d = 1'b1;
                  if (in_last) begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers. Reset aborts any session at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         prog_len_q  <= '0;
         err_cnt_q   <= '0;
         bad_op_q    <= 1'b0;
         full_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         prog_len_q  <= prog_len_d;
         err_cnt_q   <= err_cnt_d;
         bad_op_q    <= bad_op_d;
         full_q      <= full_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign prog_len  = prog_len_q;
   assign err_cnt   = err_cnt_q;
   assign bad_op    = bad_op_q;
   assign full      = full_q;
   assign done      = (state_q == ST_DONE);
   assign core_run  = done & ~bad_op_q;

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Write-side counterpart of the pipeline's opcode decoder: packs instruction fields into 16-bit instruction words and loads them into instruction memory before the core runs.
- Sits between the host/boot interface and the instruction-memory write port.
- Holds the core idle while loading. Releases it when the program is complete and clean.

Parameters:
ADDR_W, 8, instruction-memory address width; DEPTH = 2**ADDR_W words.
ERR_W, 4, width of the saturating rejected-opcode counter.

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new load session (one-cycle pulse)
in_valid  input  1  instruction field beat valid
in_ready  output  1  encoder accepts a beat this cycle
in_opcode  input  4  opcode field
in_fa  input  4  field A (rd, or data source reg for sw)
in_fb  input  4  field B (rs, or base reg for sw)
in_fc  input  4  field C (rt, or imm4 for sw/xnori)
in_last  input  1  final beat of program
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  16  encoded instruction word
prog_len  output  ADDR_W+1  words written this session
err_cnt  output  ERR_W  rejected beats, saturating
bad_op  output  1  sticky: at least one opcode rejected this session
full  output  1  memory filled to DEPTH words
done  output  1  session finished
core_run  output  1  core enable = done & ~bad_op

Behaviour:
- Reset:
  - rst_n low forces state IDLE immediately, regardless of clock.
  - All outputs go to 0; internal write pointer wptr goes to 0.
  - Instruction memory contents are not touched.
- States: IDLE, LOAD, DONE.
  - in_ready = (state == LOAD), combinational from state only.
- IDLE:
  - start moves to LOAD next cycle.
  - Same edge clears wptr, prog_len, err_cnt, bad_op, full.
  - in_valid is ignored because in_ready is 0.
- LOAD, beat accepted on (in_valid & in_ready):
  - Legal opcodes are exactly 0000 nor, 0001 nand, 0011 sw, 0111 xnori, 1111 add.
  - Legal beat:
    - Next cycle: mem_we=1, mem_addr=wptr, mem_wdata={in_opcode,in_fa,in_fb,in_fc}.
    - Registered outputs, latency 1.
    - wptr and prog_len increment.
  - Illegal beat:
    - No write.
    - err_cnt increments, saturating at 2**ERR_W-1.
    - bad_op set.
- LOAD, throughput: one beat per cycle; back-to-back writes allowed.
- mem_we:
  - One-cycle pulse per write.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
- LOAD to DONE:
  - Accepted beat with in_last=1, legal or illegal, moves to DONE next cycle.
  - Legal beat written at wptr == DEPTH-1 sets full=1 and moves to DONE, whether or not in_last is set.
  - wptr does not wrap; prog_len reads DEPTH.
- LOAD, start: ignored.
- DONE:
  - in_ready=0, done=1.
  - core_run=1 only if bad_op=0.
  - Outputs are stable until start.
- DONE, start:
  - Moves to LOAD next cycle and clears the session counters/flags.
  - done and core_run drop on that same edge.
- Reset mid-LOAD:
  - Session aborts; words already written remain in memory.
  - done=0, so the core does not run.

Test Plan:
- Reset then start, 3 beats {1111,1,2,3}, {0001,4,5,6}, {0011,7,8,9,last} -> writes addr0=0xF123, addr1=0x1456, addr2=0x3789 on consecutive cycles; prog_len=3; done=1 and core_run=1 one cycle after last write beat accepted.
- Illegal opcodes 0101 and 1000 interleaved between legal beats -> no writes for them, legal words land at contiguous addresses, err_cnt=2, bad_op=1, done=1, core_run=0.
- ADDR_W=2, 5 legal beats offered with in_valid held high, no last -> 4 writes (addr 0..3), full=1, prog_len=4, in_ready low from the cycle after the 4th acceptance, 5th beat never accepted.
- 20 illegal beats with ERR_W=4, then last beat -> err_cnt saturates at 15, prog_len=0.
- rst_n low for 1 cycle after 2 writes mid-LOAD -> all outputs 0 asynchronously, state IDLE; subsequent start and 1 legal last beat -> written at addr0.
- start pulsed during LOAD -> ignored. start in DONE -> counters cleared and core_run drops; new program rewrites from addr0.
